// File: rtl/fir_tap_loader_pkg.sv
// Shared controller definitions for the adjustable-tap FIR reload path.
// These state codes are also used by the multi-filter scheduler.
package fir_tap_loader_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        SETTLE = 2'd2
    } state_t;

endpackage

// File: rtl/fir_tap_loader_tapram.sv
// Shadow coefficient store. The host writes into it, and the loader reads it
// back through a registered read port. The storage has no reset.
module fir_tapram #(
    parameter int NTAPS = 128,
    parameter int TW    = 16,
    parameter int IW    = $clog2(NTAPS)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [IW-1:0] wr_addr,
    input  logic [TW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [IW-1:0] rd_addr,
    output logic [TW-1:0] rd_data
);

    logic [TW-1:0] mem [NTAPS];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/fir_tap_loader.sv
// Reload controller: it shifts the shadow coefficient set into the FIR tap chain,
// gates the sample strobe during the shift, and qualifies the FIR output once it is flushed.
module fir_tap_loader
    import fir_tap_loader_pkg::*;
#(
    parameter int NTAPS = 128,
    parameter int TW    = 16,
    parameter int AW    = $clog2(NTAPS),
    parameter int FLUSH = 1
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_wr_stb,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [TW-1:0] i_wr_data,
    output logic          o_wr_ack,
    output logic          o_wr_err,
    input  logic          i_load,
    input  logic          i_abort,
    input  logic          i_ce,
    output logic          o_fir_ce,
    output logic          o_tap_wr,
    output logic [TW-1:0] o_tap,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_coef_valid
);

    localparam int IW = (NTAPS > 1) ? $clog2(NTAPS) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] LAST = CW'(NTAPS - 1);
    localparam logic [CW-1:0] ALL  = CW'(NTAPS);

    state_t        state, state_next;
    logic [CW-1:0] cnt;
    logic          pending, tap_wr, done_next;
    logic          wr_en, rd_en;
    logic [IW-1:0] rd_addr;
    logic [TW-1:0] rd_data;

    always_comb begin
        wr_en   = i_wr_stb && (state == IDLE) && ({1'b0, i_wr_addr} < ALL);
        rd_en   = (state == LOAD) && (cnt != ALL) && !i_abort;
        rd_addr = IW'(LAST - cnt);
    end

    fir_tapram #(.NTAPS(NTAPS), .TW(TW), .IW(IW)) u_tapram (
        .clk     (i_clk),
        .wr_en   (wr_en),
        .wr_addr (i_wr_addr[IW-1:0]),
        .wr_data (i_wr_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) state <= IDLE;
        else            state <= state_next;
    end

    // LOAD stays one extra cycle (cnt == ALL) so that the last registered read can drain.
    always_comb begin
        state_next = state;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (pending || (i_load && !i_abort)) state_next = LOAD;
            end
            LOAD: begin
                if (i_abort) begin
                    state_next = IDLE;
                end else if (cnt == ALL) begin
                    state_next = (FLUSH != 0) ? SETTLE : IDLE;
                    done_next  = (FLUSH == 0);
                end
            end
            SETTLE: begin
                if (i_abort) begin
                    state_next = IDLE;
                end else if (i_ce && (cnt == LAST)) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        o_busy   = (state != IDLE);
        o_fir_ce = (state == LOAD) ? 1'b0 : i_ce;
        o_tap_wr = tap_wr;
        o_tap    = tap_wr ? rd_data : '0;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt          <= '0;
            pending      <= 1'b0;
            tap_wr       <= 1'b0;
            o_done       <= 1'b0;
            o_coef_valid <= 1'b0;
            o_wr_ack     <= 1'b0;
            o_wr_err     <= 1'b0;
        end else begin
            tap_wr   <= rd_en;
            o_done   <= done_next;
            o_wr_ack <= i_wr_stb;
            o_wr_err <= i_wr_stb && !wr_en;

            if (state_next != state)                cnt <= '0;
            else if (state == LOAD)                 cnt <= cnt + CW'(1);
            else if ((state == SETTLE) && i_ce)     cnt <= cnt + CW'(1);

            if (o_busy && i_abort)                          pending <= 1'b0;
            else if (o_busy && i_load)                      pending <= 1'b1;
            else if ((state == IDLE) && (state_next == LOAD)) pending <= 1'b0;

            // A completion that immediately reloads leaves the set unqualified.
            if ((state == IDLE) && (state_next == LOAD))    o_coef_valid <= 1'b0;
            else if (o_busy && i_abort)                     o_coef_valid <= 1'b0;
            else if (done_next && !(pending || i_load))     o_coef_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fir_tap_loader.sv
// Directed bench for fir_tap_loader (NTAPS=8, FLUSH=1): a cycle-timeline model
// checked every cycle, plus hand-computed literal expectations.
module tb_fir_tap_loader;

    localparam int NTAPS = 8;
    localparam int TW    = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_wr_stb, i_load, i_abort, i_ce;
    logic [AW-1:0] i_wr_addr;
    logic [TW-1:0] i_wr_data;
    logic          o_wr_ack, o_wr_err, o_fir_ce, o_tap_wr, o_busy, o_done, o_coef_valid;
    logic [TW-1:0] o_tap;

    always #5 clk = ~clk;

    fir_tap_loader #(.NTAPS(NTAPS), .TW(TW), .AW(AW), .FLUSH(1)) dut (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_wr_stb(i_wr_stb), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
        .o_wr_ack(o_wr_ack), .o_wr_err(o_wr_err),
        .i_load(i_load), .i_abort(i_abort), .i_ce(i_ce),
        .o_fir_ce(o_fir_ce), .o_tap_wr(o_tap_wr), .o_tap(o_tap),
        .o_busy(o_busy), .o_done(o_done), .o_coef_valid(o_coef_valid)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Model: phase 0 = idle, 1 = shifting (started at load_t), 2 = flushing.
    int            phase = 0, load_t = 0, ce_seen = 0, k_m, idx;
    bit            pend = 0, valid = 0, done_now = 0, ack_now = 0, err_now = 0, done_nx;
    logic          e_tw;
    logic [TW-1:0] e_tap;
    logic [TW-1:0] shadow [NTAPS];
    logic [TW-1:0] snap   [NTAPS];

    always @(negedge clk) begin
        if (!rst_n) begin
            phase = 0; pend = 0; valid = 0; done_now = 0; ack_now = 0; err_now = 0;
            chk("rst_tap_wr", o_tap_wr, 0);
            chk("rst_tap", o_tap, 0);
            chk("rst_busy", o_busy, 0);
            chk("rst_done", o_done, 0);
            chk("rst_valid", o_coef_valid, 0);
            chk("rst_ack_err", {o_wr_ack, o_wr_err}, 0);
            chk("rst_fir_ce", o_fir_ce, i_ce);
        end else begin
            e_tw = 1'b0; e_tap = '0;
            if (phase == 1) begin
                k_m = cyc - load_t;
                if (k_m >= 2) begin e_tw = 1'b1; e_tap = snap[NTAPS + 1 - k_m]; end
            end
            chk("m_busy", o_busy, phase != 0);
            chk("m_fir_ce", o_fir_ce, (phase == 1) ? 1'b0 : i_ce);
            chk("m_tap_wr", o_tap_wr, e_tw);
            chk("m_tap", o_tap, e_tap);
            chk("m_done", o_done, done_now);
            chk("m_valid", o_coef_valid, valid);
            chk("m_wr_ack", o_wr_ack, ack_now);
            chk("m_wr_err", o_wr_err, err_now);

            idx     = int'(i_wr_addr);
            ack_now = i_wr_stb;
            err_now = i_wr_stb && (phase != 0 || idx >= NTAPS);
            if (i_wr_stb && phase == 0 && idx < NTAPS) shadow[idx] = i_wr_data;
            done_nx = 0;
            if (phase == 0) begin
                if (pend || (i_load && !i_abort)) begin
                    snap = shadow; load_t = cyc; phase = 1; pend = 0; valid = 0;
                end
            end else if (i_abort) begin
                phase = 0; pend = 0; valid = 0;
            end else begin
                if (i_load) pend = 1;
                if (phase == 1) begin
                    if (cyc - load_t == NTAPS + 1) begin phase = 2; ce_seen = 0; end
                end else if (i_ce) begin
                    ce_seen++;
                    if (ce_seen == NTAPS) begin
                        phase = 0; done_nx = 1;
                        if (!pend) valid = 1;
                    end
                end
            end
            done_now = done_nx;
        end
    end

    logic [TW-1:0] cap [$];
    int            first_k, done_n, ce_n, nsh, nd;

    task automatic tick();
        @(posedge clk);
        #1;
        i_wr_stb = 1'b0; i_load = 1'b0; i_abort = 1'b0; i_ce = 1'b0;
    endtask

    task automatic wr(input int a, input int d);
        i_wr_stb = 1'b1; i_wr_addr = AW'(a); i_wr_data = TW'(d);
    endtask

    task automatic load_cycle(input int abort_k, input int reset_k, input int dup_k, input bit wr5);
        cap.delete(); first_k = 0;
        tick(); i_load = 1'b1;
        if (wr5) wr(5, 16'h0055);
        for (int k = 1; k <= NTAPS + 1; k++) begin
            tick(); i_ce = (k % 2 == 1);
            if (dup_k > 0 && (k == dup_k || k == dup_k + 2)) i_load = 1'b1;
            if (k == abort_k) i_abort = 1'b1;
            if (k == reset_k) begin
                chk("pre_reset_tap_wr", o_tap_wr, 1);
                #2 rst_n = 1'b0;
                #1;
                chk("async_tap_wr", o_tap_wr, 0);
                chk("async_busy", o_busy, 0);
            end
            @(negedge clk);
            if (rst_n) chk("load_fir_ce", o_fir_ce, 0);
            if (o_tap_wr) begin
                if (first_k == 0) first_k = k;
                cap.push_back(o_tap);
            end
            if (k == abort_k || k == reset_k) break;
        end
    endtask

    task automatic flush(input int gap);
        done_n = -1; ce_n = 0;
        for (int n = 0; n < 100; n++) begin
            tick(); i_ce = (n % gap == 0);
            @(negedge clk);
            if (o_done) begin
                done_n = n;
                chk("done_valid", o_coef_valid, 1);
                break;
            end
            if (i_ce) ce_n++;
        end
        chk("flush_done_seen", done_n >= 0, 1);
        chk("flush_ce_count", ce_n, NTAPS);
    endtask

    initial begin
        rst_n = 1'b0; i_wr_stb = 1'b0; i_load = 1'b0; i_abort = 1'b0; i_ce = 1'b0;
        i_wr_addr = '0; i_wr_data = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        tick(); i_ce = 1'b1;
        @(negedge clk);
        chk("idle_fir_ce_follow", o_fir_ce, 1);
        chk("idle_busy", o_busy, 0);

        for (int k = 0; k < NTAPS; k++) begin tick(); wr(k, k + 1); end
        tick();
        @(negedge clk);
        chk("wr_ok_ack_err", {o_wr_ack, o_wr_err}, 2'b10);

        // First load: taps 8..1 on cycles t+2..t+9, then flush on every other sample.
        load_cycle(-1, -1, -1, 0);
        chk("first_shift_k", first_k, 2);
        chk("shift_count", cap.size(), NTAPS);
        for (int j = 0; j < NTAPS; j++) chk("tap_order", cap[j], NTAPS - j);
        flush(2);
        chk("done_after_8th_ce", done_n, 15);

        // Writes while busy and writes out of range are both rejected.
        tick(); i_load = 1'b1;
        tick(); wr(3, 16'hDEAD);
        tick();
        @(negedge clk);
        chk("busy_wr_err", {o_wr_ack, o_wr_err}, 2'b11);
        for (int n = 0; n < 100 && o_busy; n++) begin tick(); i_ce = 1'b1; @(negedge clk); end
        chk("back_idle", o_busy, 0);
        tick(); wr(9, 16'h1234);
        tick();
        @(negedge clk);
        chk("range_wr_err", {o_wr_ack, o_wr_err}, 2'b11);

        // A write in the same cycle as the load is included; addr 3 keeps its old value.
        load_cycle(-1, -1, -1, 1);
        chk("same_cycle_wr", cap[2], 16'h0055);
        chk("rejected_wr_kept", cap[4], 16'h0004);
        flush(1);
        chk("done_gap1", done_n, 8);

        // Two requests during LOAD merge into exactly one extra load.
        load_cycle(-1, -1, 3, 0);
        nsh = cap.size(); nd = 0;
        for (int n = 0; n < 100; n++) begin
            tick(); i_ce = 1'b1;
            @(negedge clk);
            if (o_tap_wr) nsh++;
            if (o_done) nd++;
            if (o_coef_valid) break;
        end
        chk("dup_total_shifts", nsh, 2 * NTAPS);
        chk("dup_done_pulses", nd, 2);

        // Abort at the 4th shift.
        load_cycle(5, -1, -1, 0);
        chk("abort_shifts", cap.size(), 4);
        tick();
        @(negedge clk);
        chk("abort_idle", {o_busy, o_tap_wr, o_done, o_coef_valid}, 0);
        repeat (4) begin tick(); i_ce = 1'b1; end

        // Asynchronous reset at the 5th shift; shadow contents survive.
        load_cycle(-1, 6, -1, 0);
        tick();
        tick(); rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_valid", o_coef_valid, 0);
        load_cycle(-1, -1, -1, 0);
        chk("retained_top", cap[0], 16'h0008);
        chk("retained_wr5", cap[2], 16'h0055);
        flush(1);

        repeat (2) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, %0d failed so far", n_fail);
        $fatal(1);
    end

endmodule
